// File: rtl/jtag_master_ctrl.sv
// JTAG master sequencer: turns queued RESET / TMS_SEQ / SCAN / SCAN_FLIP commands
// into TCK/TMS/TDI bit periods and returns the captured TDO bits of scans.
module jtag_master_ctrl #(
    parameter int DIV_W    = 8,
    parameter int MAX_BITS = 32
) (
    input  logic                        mclk,
    input  logic                        reset_n,
    input  logic [DIV_W-1:0]            cfg_half_div,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [$clog2(MAX_BITS)-1:0] cmd_len,
    input  logic [MAX_BITS-1:0]         cmd_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [MAX_BITS-1:0]         rsp_data,
    output logic                        busy,
    output logic                        tck,
    output logic                        tms,
    output logic                        tdi,
    input  logic                        tdo
);

    localparam int LEN_W = $clog2(MAX_BITS);
    // A TAP reset is five TMS=1 clocks into Test-Logic-Reset plus one TMS=0 clock.
    localparam logic [LEN_W-1:0] RESET_LAST = LEN_W'(5);

    typedef enum logic [1:0] {
        OP_RESET     = 2'd0,
        OP_TMS_SEQ   = 2'd1,
        OP_SCAN      = 2'd2,
        OP_SCAN_FLIP = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_RESP
    } state_e;

    state_e              state;
    state_e              state_nxt;
    op_e                 op_q;
    op_e                 cmd_op_e;
    logic [LEN_W-1:0]    last_q;
    logic [LEN_W-1:0]    cmd_last;
    logic [LEN_W-1:0]    bit_cnt;
    logic [LEN_W-1:0]    bit_nxt;
    logic [MAX_BITS-1:0] data_q;
    logic [MAX_BITS-1:0] cap_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    phase_cnt;
    logic                armed;
    logic                accept;
    logic                phase_done;
    logic                last_bit;
    logic                is_scan;

    function automatic logic tms_bit(input op_e                 op,
                                     input logic [LEN_W-1:0]    last,
                                     input logic [MAX_BITS-1:0] data,
                                     input logic [LEN_W-1:0]    idx);
        logic b;
        case (op)
            OP_RESET:   b = (idx != last);
            OP_TMS_SEQ: b = data[idx];
            OP_SCAN:    b = 1'b0;
            default:    b = (idx == last);
        endcase
        return b;
    endfunction

    function automatic logic tdi_bit(input op_e                 op,
                                     input logic [MAX_BITS-1:0] data,
                                     input logic [LEN_W-1:0]    idx);
        return ((op == OP_SCAN) || (op == OP_SCAN_FLIP)) ? data[idx] : 1'b0;
    endfunction

    // armed keeps cmd_ready low while reset is held and releases it one edge later.
    assign cmd_ready  = armed && (state == S_IDLE) && !rsp_valid;
    assign accept     = cmd_valid && cmd_ready;
    assign cmd_op_e   = op_e'(cmd_op);
    assign cmd_last   = (cmd_op_e == OP_RESET) ? RESET_LAST : cmd_len;
    assign phase_done = (phase_cnt == div_q);
    assign last_bit   = (bit_cnt == last_q);
    assign bit_nxt    = bit_cnt + LEN_W'(1);
    assign is_scan    = (op_q == OP_SCAN) || (op_q == OP_SCAN_FLIP);

    // NOTE: every register is written with <= so all flops update from the
    // same pre-edge values, independent of statement order.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)     state_nxt = S_LOW;
            S_LOW:  if (phase_done) state_nxt = S_HIGH;
            S_HIGH: if (phase_done) state_nxt = last_bit ? S_RESP : S_LOW;
            S_RESP:                 state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            armed     <= 1'b0;
            op_q      <= OP_RESET;
            last_q    <= '0;
            data_q    <= '0;
            div_q     <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            cap_q     <= '0;
            tck       <= 1'b0;
            tms       <= 1'b0;
            tdi       <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                    if (accept) begin
                        op_q      <= cmd_op_e;
                        last_q    <= cmd_last;
                        data_q    <= cmd_data;
                        div_q     <= cfg_half_div;
                        bit_cnt   <= '0;
                        phase_cnt <= '0;
                        cap_q     <= '0;
                        busy      <= 1'b1;
                        // Bit 0 is presented during the first LOW cycle.
                        tms       <= tms_bit(cmd_op_e, cmd_last, cmd_data, '0);
                        tdi       <= tdi_bit(cmd_op_e, cmd_data, '0);
                    end
                end
                S_LOW: begin
                    if (phase_done) begin
                        phase_cnt      <= '0;
                        tck            <= 1'b1;
                        cap_q[bit_cnt] <= tdo;
                    end else begin
                        phase_cnt <= phase_cnt + DIV_W'(1);
                    end
                end
                S_HIGH: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        tck       <= 1'b0;
                        if (last_bit) begin
                            tms <= 1'b0;
                            tdi <= 1'b0;
                        end else begin
                            bit_cnt <= bit_nxt;
                            tms     <= tms_bit(op_q, last_q, data_q, bit_nxt);
                            tdi     <= tdi_bit(op_q, data_q, bit_nxt);
                        end
                    end else begin
                        phase_cnt <= phase_cnt + DIV_W'(1);
                    end
                end
                S_RESP: begin
                    busy <= 1'b0;
                    // Unused high capture bits were cleared at accept, so they read as 0.
                    if (is_scan) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap_q;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_master_ctrl.sv
// Directed and randomized bench for jtag_master_ctrl; expected waveforms and
// responses come from a per-command model of the JTAG bit sequence.
module tb_jtag_master_ctrl;

    localparam int OP_RESET     = 0;
    localparam int OP_TMS_SEQ   = 1;
    localparam int OP_SCAN      = 2;
    localparam int OP_SCAN_FLIP = 3;

    logic        mclk;
    logic        reset_n;
    logic [7:0]  cfg_half_div;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tdo_mode = 0;   // 0 loopback, 1 tied high, 2 tied low, 3 inverted loopback

    int rise_cyc[$];
    int fall_cyc[$];
    bit rise_tms[$];
    bit rise_tdi[$];
    bit exp_tms[$];
    bit exp_tdi[$];
    logic tck_prev = 1'b0;

    jtag_master_ctrl dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .cfg_half_div (cfg_half_div),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_len      (cmd_len),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .tck          (tck),
        .tms          (tms),
        .tdi          (tdi),
        .tdo          (tdo)
    );

    assign tdo = (tdo_mode == 0) ? tdi :
                 (tdo_mode == 1) ? 1'b1 :
                 (tdo_mode == 2) ? 1'b0 : ~tdi;

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    always @(posedge mclk) cyc <= cyc + 1;

    // Records TMS/TDI at every TCK rise and the cycle of every TCK edge.
    always @(negedge mclk) begin
        if (tck && !tck_prev) begin
            rise_cyc.push_back(cyc);
            rise_tms.push_back(tms);
            rise_tdi.push_back(tdi);
        end
        if (!tck && tck_prev) fall_cyc.push_back(cyc);
        tck_prev <= tck;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge mclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model: the TMS/TDI value each TCK rise must carry.
    function automatic void build_exp(input int op, input int len, input logic [31:0] data);
        int n;
        exp_tms.delete();
        exp_tdi.delete();
        n = (op == OP_RESET) ? 6 : len + 1;
        for (int i = 0; i < n; i++) begin
            case (op)
                OP_RESET:   begin exp_tms.push_back(i < 5);     exp_tdi.push_back(1'b0);    end
                OP_TMS_SEQ: begin exp_tms.push_back(data[i]);   exp_tdi.push_back(1'b0);    end
                OP_SCAN:    begin exp_tms.push_back(1'b0);      exp_tdi.push_back(data[i]); end
                default:    begin exp_tms.push_back(i == n - 1); exp_tdi.push_back(data[i]); end
            endcase
        end
    endfunction

    function automatic logic [31:0] expected_rsp(input int len, input logic [31:0] data, input int mode);
        logic [63:0] mask;
        logic [31:0] src;
        mask = (64'd1 << (len + 1)) - 64'd1;
        case (mode)
            0:       src = data;
            1:       src = '1;
            2:       src = '0;
            default: src = ~data;
        endcase
        return src & mask[31:0];
    endfunction

    task automatic send_cmd(input int op, input int len, input logic [31:0] data,
                            input int div, output int acc);
        bit found;
        rise_cyc.delete();
        fall_cyc.delete();
        rise_tms.delete();
        rise_tdi.delete();
        cmd_op       = 2'(op);
        cmd_len      = 5'(len);
        cmd_data     = data;
        cfg_half_div = 8'(div);
        cmd_valid    = 1'b1;
        found        = 1'b0;
        acc          = -1;
        for (int k = 0; k < 400 && !found; k++) begin
            if (cmd_ready) begin
                found = 1'b1;
                acc   = cyc + 1;
            end
            tick();
        end
        cmd_valid    = 1'b0;
        cfg_half_div = 8'($urandom);   // must not disturb the running command
        check1("cmd_accepted", found, 1'b1);
    endtask

    task automatic finish_cmd(input int op, input int len, input logic [31:0] data,
                              input int div, input int acc, input bit handshake,
                              output logic [31:0] rsp_exp);
        int n;
        int done_cyc;
        bit early;
        bit done;
        build_exp(op, len, data);
        n        = exp_tms.size();
        rsp_exp  = expected_rsp(len, data, tdo_mode);
        early    = 1'b0;
        done     = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 2 * (div + 1) * n + 40 && !done; k++) begin
            if (!busy) begin
                done     = 1'b1;
                done_cyc = cyc;
            end else begin
                if (rsp_valid) early = 1'b1;
                tick();
            end
        end
        check("busy_fall_cycle", done_cyc, acc + 2 * (div + 1) * n + 1);
        check1("no_rsp_while_busy", early, 1'b0);
        check("tck_rise_count", rise_cyc.size(), n);
        for (int i = 0; i < n && i < rise_cyc.size(); i++) begin
            check1($sformatf("tms_at_rise[%0d]", i), rise_tms[i], exp_tms[i]);
            check1($sformatf("tdi_at_rise[%0d]", i), rise_tdi[i], exp_tdi[i]);
            check($sformatf("rise_cycle[%0d]", i), rise_cyc[i], acc + (div + 1) * (2 * i + 1));
            if (i < fall_cyc.size())
                check($sformatf("high_width[%0d]", i), fall_cyc[i] - rise_cyc[i], div + 1);
        end
        check("idle_pins", {29'd0, tck, tms, tdi}, 32'd0);
        if (op >= OP_SCAN) begin
            check1("rsp_valid_at_end", rsp_valid, 1'b1);
            check("rsp_data", rsp_data, rsp_exp);
            if (handshake) begin
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                check1("rsp_valid_after_ack", rsp_valid, 1'b0);
                check1("cmd_ready_after_ack", cmd_ready, 1'b1);
            end
        end else begin
            check1("no_rsp_at_end", rsp_valid, 1'b0);
            tick();
            check1("no_rsp_after_end", rsp_valid, 1'b0);
            check1("cmd_ready_after_end", cmd_ready, 1'b1);
        end
    endtask

    initial begin
        int acc;
        int acc2;
        int h;
        int op;
        int len;
        int div;
        logic [31:0] d;
        logic [31:0] rexp;

        reset_n      = 1'b0;
        cfg_half_div = '0;
        cmd_valid    = 1'b0;
        cmd_op       = '0;
        cmd_len      = '0;
        cmd_data     = '0;
        rsp_ready    = 1'b0;

        // Reset values, then cmd_ready one edge after release.
        tick();
        tick();
        check1("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_pins", {29'd0, tck, tms, tdi}, 32'd0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'd0);
        reset_n = 1'b1;
        tick();
        check1("cmd_ready_after_release", cmd_ready, 1'b1);
        check1("busy_after_release", busy, 1'b0);

        // TAP reset, div=0; cmd_len is don't-care.
        tdo_mode = 0;
        send_cmd(OP_RESET, 17, 32'hFFFF_FFFF, 0, acc);
        finish_cmd(OP_RESET, 17, 32'hFFFF_FFFF, 0, acc, 1'b1, rexp);

        // TMS sequence 0,1,1,0,1 with 4-cycle half periods.
        send_cmd(OP_TMS_SEQ, 4, 32'h16, 3, acc);
        finish_cmd(OP_TMS_SEQ, 4, 32'h16, 3, acc, 1'b1, rexp);

        // Full 32-bit loopback scan, div=0: response 65 cycles after accept.
        tdo_mode = 0;
        send_cmd(OP_SCAN, 31, 32'hA5A5_5A5A, 0, acc);
        finish_cmd(OP_SCAN, 31, 32'hA5A5_5A5A, 0, acc, 1'b1, rexp);

        // SCAN_FLIP with TDO tied high.
        tdo_mode = 1;
        send_cmd(OP_SCAN_FLIP, 7, 32'h3C, 1, acc);
        finish_cmd(OP_SCAN_FLIP, 7, 32'h3C, 1, acc, 1'b1, rexp);

        // Response backpressure with a queued command behind it.
        tdo_mode = 3;
        d = $urandom;
        send_cmd(OP_SCAN, 15, d, 1, acc);
        finish_cmd(OP_SCAN, 15, d, 1, acc, 1'b0, rexp);
        cmd_op    = 2'(OP_TMS_SEQ);
        cmd_len   = 5'd3;
        cmd_data  = 32'h5;
        cmd_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check1("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_data", rsp_data, rexp);
            check1("hold_cmd_ready", cmd_ready, 1'b0);
            check1("hold_busy", busy, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        h = cyc + 1;
        send_cmd(OP_TMS_SEQ, 3, 32'h5, 0, acc2);
        rsp_ready = 1'b0;
        check("queued_accept_cycle", acc2, h + 1);
        finish_cmd(OP_TMS_SEQ, 3, 32'h5, 0, acc2, 1'b1, rexp);

        // Reset pulse during bit 3 of a scan.
        tdo_mode = 0;
        send_cmd(OP_SCAN, 20, $urandom, 0, acc);
        for (int k = 0; k < 200 && rise_cyc.size() < 4; k++) tick();
        check1("reached_bit3", rise_cyc.size() >= 4, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_pins", {29'd0, tck, tms, tdi}, 32'd0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_rsp_valid", rsp_valid, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check1("postrst_rsp_valid", rsp_valid, 1'b0);
        check1("postrst_cmd_ready", cmd_ready, 1'b1);
        d = $urandom;
        send_cmd(OP_SCAN_FLIP, 9, d, 2, acc);
        finish_cmd(OP_SCAN_FLIP, 9, d, 2, acc, 1'b1, rexp);

        // Randomized commands; rsp_ready is sometimes held high early.
        for (int t = 0; t < 16; t++) begin
            op       = $urandom_range(0, 3);
            len      = $urandom_range(0, 31);
            div      = $urandom_range(0, 3);
            d        = $urandom;
            tdo_mode = $urandom_range(0, 3);
            send_cmd(op, len, d, div, acc);
            rsp_ready = 1'($urandom_range(0, 1));
            finish_cmd(op, len, d, div, acc, 1'b1, rexp);
            rsp_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
